// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pattern_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Pattern the downstream Moore detectors are built to recognise.
  localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b1101;

  // Width of a down-counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-stream bundle between a pattern source and its consumer.
interface seq_pattern_tx_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) ();

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] num_rep;
  logic [GAP_W-1:0] gap_len;
  logic             dout;
  logic             dout_vld;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, num_rep, gap_len,
    input  dout, dout_vld, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, num_rep, gap_len,
    output dout, dout_vld, frame_start, busy, done
  );

endinterface

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register; zeros shift in from the LSB end.
module seq_piso_shreg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] sr;

  // Load has priority over shift; register empties to zero as bits leave.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = sr[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// num_rep times with gap_len idle cycles between frames.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input logic            clk,
  input logic            rst,
  seq_pattern_tx_if.slave bus
);

  localparam int unsigned     BIT_W    = cnt_width(PAT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [PAT_W-1:0] pat_q;
  logic             vld_q;
  logic             fs_q;
  logic             busy_q;
  logic             done_q;

  logic             last_bit;
  logic             more_frames;
  logic             load;
  logic             shift;
  logic [PAT_W-1:0] load_val;
  logic             msb;

  // Shift-register control: load on accept, back-to-back reload, or gap end.
  always_comb begin
    last_bit    = 1'b0;
    more_frames = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    load_val    = pat_q;
    last_bit    = (state == S_SEND) && (bit_cnt == '0);
    more_frames = (rep_cnt > REP_W'(1));
    if (state == S_IDLE) begin
      load_val = bus.pattern;
      load     = bus.start;
    end else if (state == S_GAP) begin
      load = (gap_cnt == GAP_W'(1));
    end else if (last_bit && more_frames && (gap_q == '0)) begin
      load = 1'b1;
    end
    shift = (state == S_SEND) && !load;
  end

  // The shift register itself is the dout flop: it is zero outside SEND
  // because every frame shifts fully out before GAP/DONE is entered.
  seq_piso_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (load_val),
    .msb   (msb)
  );

  // Control FSM with bit/gap/repeat down-counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pat_q   <= bus.pattern;
            rep_cnt <= (bus.num_rep == '0) ? REP_W'(1) : bus.num_rep;
            gap_q   <= bus.gap_len;
            bit_cnt <= BIT_LAST;
            vld_q   <= 1'b1;
            fs_q    <= 1'b1;
            busy_q  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_cnt == '0) begin
            rep_cnt <= (rep_cnt != '0) ? rep_cnt - REP_W'(1) : '0;
            if (more_frames && (gap_q == '0)) begin
              bit_cnt <= BIT_LAST;
              fs_q    <= 1'b1;
            end else if (more_frames) begin
              gap_cnt <= gap_q;
              vld_q   <= 1'b0;
              fs_q    <= 1'b0;
              state   <= S_GAP;
            end else begin
              vld_q  <= 1'b0;
              fs_q   <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            bit_cnt <= bit_cnt - BIT_W'(1);
            fs_q    <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            bit_cnt <= BIT_LAST;
            vld_q   <= 1'b1;
            fs_q    <= 1'b1;
            state   <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout        = msb;
  assign bus.dout_vld    = vld_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a frame model fills a queue of
// expected per-cycle outputs {dout, dout_vld, frame_start, busy, done}.
module tb_seq_pattern_tx;
  import seq_pattern_tx_pkg::*;

  localparam int unsigned PW = 4;
  localparam int unsigned RW = 4;
  localparam int unsigned GW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PW), .REP_W(RW), .GAP_W(GW)) bus ();

  seq_pattern_tx #(.PAT_W(PW), .REP_W(RW), .GAP_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  obs_v;
  logic [4:0]  e;
  int unsigned k;

  assign obs_v = {bus.dout, bus.dout_vld, bus.frame_start, bus.busy, bus.done};

  // Expected cycles 1..end for one accepted start, plus one trailing idle cycle.
  function automatic void push_frames(input logic [PW-1:0] pat,
                                      input int unsigned rep,
                                      input int unsigned gap);
    int unsigned r;
    r = (rep == 0) ? 1 : rep;
    for (int unsigned f = 0; f < r; f++) begin
      for (int unsigned b = 0; b < PW; b++)
        exp_q.push_back({pat[PW-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
      if (f + 1 < r)
        for (int unsigned g = 0; g < gap; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00000);
  endfunction

  task automatic drive_start(input logic [PW-1:0] pat,
                             input logic [RW-1:0] rep,
                             input logic [GW-1:0] gap);
    @(negedge clk);
    bus.pattern = pat;
    bus.num_rep = rep;
    bus.gap_len = gap;
    bus.start   = 1'b1;
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.num_rep = '0;
    bus.gap_len = '0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", obs_v, 5'b00000);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold: got %b expected %b", obs_v, 5'b00000);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_release: got %b expected %b", obs_v, 5'b00000);
    end
  endtask

  task automatic test_single();
    drive_start(SEQ_PAT_DEFAULT, RW'(1), GW'(0));
    push_frames(SEQ_PAT_DEFAULT, 1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL single cycle %0d: got %b expected %b", k, obs_v, e);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic test_gap();
    drive_start(SEQ_PAT_DEFAULT, RW'(3), GW'(2));
    push_frames(SEQ_PAT_DEFAULT, 3, 2);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL gap cycle %0d: got %b expected %b", k, obs_v, e);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    drive_start(SEQ_PAT_DEFAULT, RW'(2), GW'(0));
    push_frames(SEQ_PAT_DEFAULT, 2, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs_v, e);
      end
      bus.start = 1'b0;
    end
  endtask

  // start stays high through SEND and DONE; pattern changes after the latch.
  task automatic test_hold_start();
    drive_start(4'b1011, RW'(1), GW'(0));
    push_frames(4'b1011, 1, 0);
    exp_q.push_back(5'b00000);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL hold_start cycle %0d: got %b expected %b", k, obs_v, e);
      end
      if (k == 1) bus.pattern = 4'b0000;
      if (k == 5) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_start(SEQ_PAT_DEFAULT, RW'(1), GW'(0));
    push_frames(SEQ_PAT_DEFAULT, 1, 0);
    for (int unsigned c = 1; c <= 2; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", c, obs_v, e);
      end
      bus.start = 1'b0;
    end
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_err++;
      $display("FAIL abort_async: got %b expected %b", obs_v, 5'b00000);
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== 5'b00000) begin
        n_err++;
        $display("FAIL abort_no_done: got %b expected %b", obs_v, 5'b00000);
      end
    end
    rst = 1'b1;
    drive_start(SEQ_PAT_DEFAULT, RW'(1), GW'(0));
    push_frames(SEQ_PAT_DEFAULT, 1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL restart cycle %0d: got %b expected %b", k, obs_v, e);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic test_num_rep_zero();
    drive_start(4'b0110, RW'(0), GW'(3));
    push_frames(4'b0110, 0, 3);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_err++;
        $display("FAIL num_rep_zero cycle %0d: got %b expected %b", k, obs_v, e);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] pat;
    int unsigned   rep;
    int unsigned   gap;
    for (int unsigned i = 0; i < 6; i++) begin
      pat = PW'($urandom);
      rep = $urandom_range(0, 3);
      gap = $urandom_range(0, 3);
      drive_start(pat, RW'(rep), GW'(gap));
      push_frames(pat, rep, gap);
      k = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        k++;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_v !== e) begin
          n_err++;
          $display("FAIL random[%0d] pat=%b rep=%0d gap=%0d cycle %0d: got %b expected %b",
                   i, pat, rep, gap, k, obs_v, e);
        end
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_hold_start();
    test_reset_mid_frame();
    test_num_rep_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
